// File: rtl/irq_id_arbiter_if.sv
// Interrupt bus between the event unit / core and irq_id_arbiter.
// Carries the level lines and enable in, and the request, ID and status pulses out.
interface irq_id_arbiter_if #(
    parameter int NUM_IRQ  = 32,
    parameter int ID_WIDTH = 5
);
    logic [NUM_IRQ-1:0]  irq_i;
    logic                enable_i;
    logic                irq_ack_i;
    logic [ID_WIDTH-1:0] irq_ack_id_i;
    logic                irq_req_o;
    logic [ID_WIDTH-1:0] irq_id_o;
    logic                irq_pending_o;
    logic                ack_err_o;
    logic                timeout_o;

    // Handshake: irq_req_o stays high with irq_id_o until the core returns a one-cycle
    // irq_ack_i whose irq_ack_id_i equals irq_id_o in that same cycle; the request drops
    // on the following edge. Any other acknowledge pulses ack_err_o one cycle later.
    modport slave (
        input  irq_i, enable_i, irq_ack_i, irq_ack_id_i,
        output irq_req_o, irq_id_o, irq_pending_o, ack_err_o, timeout_o
    );
    modport master (
        output irq_i, enable_i, irq_ack_i, irq_ack_id_i,
        input  irq_req_o, irq_id_o, irq_pending_o, ack_err_o, timeout_o
    );
endinterface

// File: rtl/irq_id_arbiter.sv
// Picks the highest pending interrupt line, requests the core with its ID, and after an
// acknowledge holds off new requests until the served line clears or a timeout expires.
module irq_id_arbiter #(
    parameter int NUM_IRQ     = 32,
    parameter int ID_WIDTH    = 5,
    parameter int CLR_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             HRESETn,
    irq_id_arbiter_if.slave  bus,
    output logic [1:0]       state_o
);
    localparam int CNT_W = $clog2(CLR_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_CLR = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [ID_WIDTH-1:0] served_q, served_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W:0]      cnt_inc;
    logic                err_q, err_d;
    logic                tmo_q, tmo_d;
    logic [ID_WIDTH-1:0] winner;
    logic                any_irq;
    logic                ack_valid;

    // Later iterations overwrite earlier ones, so the highest set index wins.
    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.irq_i[i]) winner = ID_WIDTH'(i);
        end
    end

    assign any_irq   = |bus.irq_i;
    assign ack_valid = bus.irq_ack_i && (bus.irq_ack_id_i == id_q);
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    always_ff @(posedge clk_i or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            id_q     <= '0;
            served_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            id_q     <= id_d;
            served_q <= served_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        id_d     = id_q;
        served_d = served_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        tmo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                err_d = bus.irq_ack_i;
                if (bus.enable_i && any_irq) begin
                    id_d    = winner;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A matching acknowledge beats a simultaneous enable drop or line drop.
                if (ack_valid) begin
                    req_d    = 1'b0;
                    served_d = id_q;
                    cnt_d    = '0;
                    state_d  = WAIT_CLR;
                end else begin
                    err_d = bus.irq_ack_i;
                    if (!any_irq || !bus.enable_i) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        id_d = winner;
                    end
                end
            end
            WAIT_CLR: begin
                req_d = 1'b0;
                err_d = bus.irq_ack_i;
                if (!bus.irq_i[served_q]) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_inc[CNT_W-1:0];
                    if (cnt_inc >= (CNT_W + 1)'(CLR_TIMEOUT)) begin
                        tmo_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.irq_req_o     = req_q;
    assign bus.irq_id_o      = id_q;
    assign bus.irq_pending_o = any_irq;
    assign bus.ack_err_o     = err_q;
    assign bus.timeout_o     = tmo_q;
    assign state_o           = state_q;
endmodule
